// File: rtl/poly_voice_pkg.sv
// Shared types and constants for the polyphonic voice allocator: mix FSM states
// and the signed saturation limits of the mixed sample.
package poly_voice_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    SUM  = 2'd3
  } mix_state_t;

  function automatic longint sat_max(input int sample_w);
    return (longint'(1) <<< (sample_w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int sample_w);
    return -(longint'(1) <<< (sample_w - 1));
  endfunction

endpackage

// File: rtl/poly_voice_allocator_if.sv
// Bus between song reader / note players and the voice allocator.
// The allocator uses the slave modport; the driving side uses master.
interface poly_voice_allocator_if #(
  parameter int VOICES   = 4,
  parameter int NOTE_W   = 6,
  parameter int DUR_W    = 6,
  parameter int SAMPLE_W = 16
);
  localparam int VIDX_W = $clog2(VOICES);

  logic                         play;
  logic                         beat;
  logic                         load_new_note;
  logic [NOTE_W-1:0]            note_to_load;
  logic [DUR_W-1:0]             duration_to_load;
  logic                         generate_next_sample;
  logic [VOICES*SAMPLE_W-1:0]   voice_sample;
  logic [VOICES-1:0]            voice_sample_ready;
  logic [VOICES*NOTE_W-1:0]     voice_note;
  logic [VOICES-1:0]            voice_active;
  logic [VOICES-1:0]            voice_load;
  logic                         voice_generate;
  logic [SAMPLE_W-1:0]          sample_out;
  logic                         new_sample_ready;
  logic                         note_dropped;
  logic [VIDX_W-1:0]            last_voice;

  modport slave (
    input  play, beat, load_new_note, note_to_load, duration_to_load,
           generate_next_sample, voice_sample, voice_sample_ready,
    output voice_note, voice_active, voice_load, voice_generate,
           sample_out, new_sample_ready, note_dropped, last_voice
  );

  modport master (
    output play, beat, load_new_note, note_to_load, duration_to_load,
           generate_next_sample, voice_sample, voice_sample_ready,
    input  voice_note, voice_active, voice_load, voice_generate,
           sample_out, new_sample_ready, note_dropped, last_voice
  );
endinterface

// File: rtl/poly_voice_allocator_voice_select.sv
// Combinational slot chooser: lowest-index free slot, or (when STEAL is set and
// nothing is free) the slot with the smallest remaining count, lowest index on ties.
module voice_select #(
  parameter int VOICES = 4,
  parameter int DUR_W  = 6,
  parameter int VIDX_W = $clog2(VOICES),
  parameter bit STEAL  = 1'b0
) (
  input  logic [VOICES*DUR_W-1:0] i_cnt,
  output logic [VIDX_W-1:0]       o_idx,
  output logic                    o_found
);
  logic [VIDX_W-1:0] w_free_idx;
  logic [VIDX_W-1:0] w_min_idx;
  logic [DUR_W-1:0]  w_min_val;

  // NOTE: every output and temporary gets a default first so no latch is inferred.
  always_comb begin
    o_found    = 1'b0;
    w_free_idx = '0;
    w_min_idx  = '0;
    w_min_val  = i_cnt[DUR_W-1:0];
    // Scan high to low so the last hit is the lowest free index.
    for (int i = VOICES - 1; i >= 0; i--) begin
      if (i_cnt[i*DUR_W +: DUR_W] == '0) begin
        o_found    = 1'b1;
        w_free_idx = VIDX_W'(i);
      end
    end
    for (int i = 1; i < VOICES; i++) begin
      if (i_cnt[i*DUR_W +: DUR_W] < w_min_val) begin
        w_min_val = i_cnt[i*DUR_W +: DUR_W];
        w_min_idx = VIDX_W'(i);
      end
    end
    o_idx = (o_found || !STEAL) ? w_free_idx : w_min_idx;
  end
endmodule

// File: rtl/poly_voice_allocator.sv
// Polyphonic voice allocator and sample mixer. Define VOICE_STEAL_EN to steal the
// slot with the least remaining duration when all slots are busy; otherwise the load is dropped.
module poly_voice_allocator #(
  parameter int VOICES   = 4,
  parameter int NOTE_W   = 6,
  parameter int DUR_W    = 6,
  parameter int SAMPLE_W = 16,
  parameter int VIDX_W   = $clog2(VOICES)
) (
  input logic                    clk,
  input logic                    reset,
  poly_voice_allocator_if.slave  bus
);
  import poly_voice_pkg::*;

  localparam int SUM_W = SAMPLE_W + VIDX_W + 1;
  localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'(sat_max(SAMPLE_W));
  localparam logic signed [SUM_W-1:0] SAT_LO = SUM_W'(sat_min(SAMPLE_W));

`ifdef VOICE_STEAL_EN
  localparam bit STEAL = 1'b1;
`else
  localparam bit STEAL = 1'b0;
`endif

  logic [DUR_W-1:0]           r_cnt [VOICES];
  logic [NOTE_W-1:0]          r_note [VOICES];
  logic [VOICES-1:0]          r_active;
  logic [VOICES-1:0]          r_voice_load;
  logic [VIDX_W-1:0]          r_last_voice;
  logic                       r_note_dropped;

  mix_state_t                 r_state;
  logic [VOICES-1:0]          r_got;
  logic [VOICES-1:0]          r_snap;
  logic                       r_voice_generate;
  logic                       r_new_sample_ready;
  logic [SAMPLE_W-1:0]        r_sample_out;
  logic signed [SAMPLE_W-1:0] r_lat [VOICES];

  logic [VOICES*DUR_W-1:0]    w_cnt_flat;
  logic [DUR_W-1:0]           w_cnt_next [VOICES];
  logic signed [SAMPLE_W-1:0] w_smp [VOICES];
  logic signed [SAMPLE_W-1:0] w_lat_next [VOICES];
  logic [VIDX_W-1:0]          w_sel_idx;
  logic                       w_free_found;
  logic                       w_load_req;
  logic                       w_accept;
  logic                       w_drop;
  logic                       w_count_en;
  logic [VOICES-1:0]          w_got_next;
  logic signed [SUM_W-1:0]    w_sum;
  logic [SAMPLE_W-1:0]        w_sat;

  for (genvar g = 0; g < VOICES; g++) begin : g_voice
    assign w_cnt_flat[g*DUR_W +: DUR_W]      = r_cnt[g];
    assign bus.voice_note[g*NOTE_W +: NOTE_W] = r_note[g];
    assign w_smp[g] = bus.voice_sample[g*SAMPLE_W +: SAMPLE_W];
  end

  voice_select #(
    .VOICES (VOICES),
    .DUR_W  (DUR_W),
    .VIDX_W (VIDX_W),
    .STEAL  (STEAL)
  ) u_select (
    .i_cnt   (w_cnt_flat),
    .o_idx   (w_sel_idx),
    .o_found (w_free_found)
  );

  assign w_load_req = bus.load_new_note && (bus.duration_to_load != '0);
  assign w_accept   = w_load_req && (w_free_found || STEAL);
  assign w_drop     = w_load_req && !w_free_found && !STEAL;
  assign w_count_en = bus.beat && bus.play;

  // The selector sees pre-beat counts, so a slot freed by this beat is not reusable yet.
  always_comb begin
    for (int i = 0; i < VOICES; i++) begin
      w_cnt_next[i] = r_cnt[i];
      if (w_accept && (w_sel_idx == VIDX_W'(i)))
        w_cnt_next[i] = bus.duration_to_load;
      else if (w_count_en && (r_cnt[i] != '0))
        w_cnt_next[i] = r_cnt[i] - DUR_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every always_ff reads pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < VOICES; i++) begin
        r_cnt[i]  <= '0;
        r_note[i] <= '0;
      end
      r_active       <= '0;
      r_voice_load   <= '0;
      r_last_voice   <= '0;
      r_note_dropped <= 1'b0;
    end else begin
      r_voice_load   <= '0;
      r_note_dropped <= w_drop;
      for (int i = 0; i < VOICES; i++) begin
        r_cnt[i]    <= w_cnt_next[i];
        r_active[i] <= (w_cnt_next[i] != '0);
      end
      if (w_accept) begin
        r_note[w_sel_idx]       <= bus.note_to_load;
        r_voice_load[w_sel_idx] <= 1'b1;
        r_last_voice            <= w_sel_idx;
      end
    end
  end

  // The sum includes a sample arriving this cycle so SUM is entered without an extra wait.
  always_comb begin
    w_got_next = r_got | bus.voice_sample_ready;
    w_sum      = '0;
    for (int i = 0; i < VOICES; i++) begin
      w_lat_next[i] = bus.voice_sample_ready[i] ? w_smp[i] : r_lat[i];
      if (r_snap[i])
        w_sum = w_sum + SUM_W'(w_lat_next[i]);
    end
    if (w_sum > SAT_HI)
      w_sat = SAT_HI[SAMPLE_W-1:0];
    else if (w_sum < SAT_LO)
      w_sat = SAT_LO[SAMPLE_W-1:0];
    else
      w_sat = w_sum[SAMPLE_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state            <= IDLE;
      r_got              <= '0;
      r_snap             <= '0;
      r_voice_generate   <= 1'b0;
      r_new_sample_ready <= 1'b0;
      r_sample_out       <= '0;
    end else begin
      r_voice_generate   <= 1'b0;
      r_new_sample_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.generate_next_sample) begin
            r_state          <= REQ;
            r_voice_generate <= 1'b1;
          end
        end
        REQ: begin
          r_got   <= ~r_active;
          r_snap  <= r_active;
          r_state <= WAIT;
        end
        WAIT: begin
          r_got <= w_got_next;
          if (&w_got_next) begin
            r_sample_out       <= w_sat;
            r_new_sample_ready <= 1'b1;
            r_state            <= SUM;
          end
        end
        SUM:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // NOTE: the sample latches are pure datapath and are always written before use, so they carry no reset.
  always_ff @(posedge clk) begin
    if (r_state == WAIT) begin
      for (int i = 0; i < VOICES; i++)
        r_lat[i] <= w_lat_next[i];
    end
  end

  assign bus.voice_active     = r_active;
  assign bus.voice_load       = r_voice_load;
  assign bus.last_voice       = r_last_voice;
  assign bus.note_dropped     = r_note_dropped;
  assign bus.voice_generate   = r_voice_generate;
  assign bus.new_sample_ready = r_new_sample_ready;
  assign bus.sample_out       = r_sample_out;

endmodule

// File: tb/tb_poly_voice_allocator.sv
// Randomised self-checking bench for poly_voice_allocator against a slot/duration
// model kept as plain integer arrays, plus directed saturation and handshake cases.
module tb_poly_voice_allocator;
  localparam int VOICES   = 4;
  localparam int NOTE_W   = 6;
  localparam int DUR_W    = 6;
  localparam int SAMPLE_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  poly_voice_allocator_if #(.VOICES(VOICES), .NOTE_W(NOTE_W), .DUR_W(DUR_W),
                            .SAMPLE_W(SAMPLE_W)) bus ();

  poly_voice_allocator #(.VOICES(VOICES), .NOTE_W(NOTE_W), .DUR_W(DUR_W),
                         .SAMPLE_W(SAMPLE_W)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int              n_cmp = 0;
  int              n_err = 0;
  int              m_cnt  [VOICES];
  int              m_note [VOICES];
  logic [VOICES-1:0] e_load;
  logic            e_drop;
  int              e_last;
  int              nsr_seen;
  logic [15:0]     nsr_val;
  int              f_s [VOICES];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VOICES-1:0] m_active();
    logic [VOICES-1:0] a = '0;
    for (int i = 0; i < VOICES; i++) a[i] = (m_cnt[i] != 0);
    return a;
  endfunction

  function automatic logic [VOICES*NOTE_W-1:0] m_notes();
    logic [VOICES*NOTE_W-1:0] v = '0;
    for (int i = 0; i < VOICES; i++) v[i*NOTE_W +: NOTE_W] = NOTE_W'(m_note[i]);
    return v;
  endfunction

  function automatic logic [15:0] clamp16(input int s);
    logic [31:0] t = s;
    if (s > 32767) return 16'h7fff;
    if (s < -32768) return 16'h8000;
    return t[15:0];
  endfunction

  // Advance one clock: update the model from the applied inputs, then compare.
  task automatic tick();
    int tgt = -1;
    int dur = int'(bus.duration_to_load);
    e_load = '0;
    e_drop = 1'b0;
    if (rst) begin
      for (int i = 0; i < VOICES; i++) begin m_cnt[i] = 0; m_note[i] = 0; end
      e_last = 0;
    end else begin
      if (bus.load_new_note && dur != 0) begin
        for (int i = 0; i < VOICES; i++)
          if (tgt < 0 && m_cnt[i] == 0) tgt = i;
        if (tgt < 0) begin
`ifdef VOICE_STEAL_EN
          tgt = 0;
          for (int i = 1; i < VOICES; i++) if (m_cnt[i] < m_cnt[tgt]) tgt = i;
`else
          e_drop = 1'b1;
`endif
        end
      end
      for (int i = 0; i < VOICES; i++) begin
        if (i == tgt) begin
          m_cnt[i]  = dur;
          m_note[i] = int'(bus.note_to_load);
        end else if (bus.beat && bus.play && m_cnt[i] > 0) begin
          m_cnt[i]--;
        end
      end
      if (tgt >= 0) begin e_load[tgt] = 1'b1; e_last = tgt; end
    end
    @(posedge clk);
    #1;
    check("active", 64'(bus.voice_active), 64'(m_active()));
    check("notes", 64'(bus.voice_note), 64'(m_notes()));
    check("load", 64'(bus.voice_load), 64'(e_load));
    check("drop", 64'(bus.note_dropped), 64'(e_drop));
    check("last", 64'(bus.last_voice), 64'(e_last));
    if (bus.new_sample_ready) begin
      nsr_seen++;
      nsr_val = bus.sample_out;
    end
    bus.load_new_note        = 1'b0;
    bus.beat                 = 1'b0;
    bus.generate_next_sample = 1'b0;
    bus.voice_sample_ready   = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_vgen", 64'(bus.voice_generate), 64'd0);
    check("rst_nsr", 64'(bus.new_sample_ready), 64'd0);
    check("rst_sample", 64'(bus.sample_out), 64'd0);
  endtask

  task automatic load(input int note, input int dur);
    bus.load_new_note    = 1'b1;
    bus.note_to_load     = NOTE_W'(note);
    bus.duration_to_load = DUR_W'(dur);
    tick();
  endtask

  task automatic rand_inputs();
    bus.load_new_note    = ($urandom % 3) == 0;
    bus.note_to_load     = NOTE_W'($urandom);
    bus.duration_to_load = DUR_W'($urandom_range(0, 7));
    bus.beat             = ($urandom % 3) == 0;
    bus.play             = ($urandom % 4) != 0;
  endtask

  // One mix frame with samples in f_s; readies of snapshot voices arrive gap cycles apart.
  task automatic frame(input string tag, input int gap, input bit traffic);
    logic [VOICES-1:0] snap;
    int sum = 0;
    int w = 0;
    nsr_seen = 0;
    for (int i = 0; i < VOICES; i++)
      bus.voice_sample[i*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(f_s[i]);
    bus.generate_next_sample = 1'b1;
    tick();
    check({tag, "_vgen_hi"}, 64'(bus.voice_generate), 64'd1);
    snap = m_active();
    tick();
    check({tag, "_vgen_lo"}, 64'(bus.voice_generate), 64'd0);
    for (int i = 0; i < VOICES; i++) begin
      if (snap[i]) begin
        sum += f_s[i];
        for (int k = 0; k < gap; k++) begin
          if (traffic) rand_inputs();
          tick();
        end
        if (traffic) begin
          rand_inputs();
          bus.voice_sample_ready = VOICES'($urandom) & ~snap;
        end
        bus.voice_sample_ready[i] = 1'b1;
        tick();
      end
    end
    while (nsr_seen == 0 && w < 10) begin tick(); w++; end
    tick();
    tick();
    check({tag, "_pulses"}, 64'(nsr_seen), 64'd1);
    check({tag, "_value"}, 64'(nsr_val), 64'(clamp16(sum)));
  endtask

  task automatic idle_latency(input string tag);
    int lat = 0;
    nsr_seen = 0;
    bus.generate_next_sample = 1'b1;
    while (nsr_seen == 0 && lat < 8) begin tick(); lat++; end
    check({tag, "_latency"}, 64'(lat), 64'd3);
    check({tag, "_value"}, 64'(nsr_val), 64'd0);
  endtask

  initial begin
    bus.play = 1'b0; bus.beat = 1'b0; bus.load_new_note = 1'b0;
    bus.note_to_load = '0; bus.duration_to_load = '0;
    bus.generate_next_sample = 1'b0; bus.voice_sample = '0; bus.voice_sample_ready = '0;
    nsr_seen = 0; nsr_val = '0;

    do_reset();
    bus.play = 1'b1;
    load(40, 3);
    check("tp_load_a", 64'(bus.voice_load), 64'b0001);
    check("tp_last_a", 64'(bus.last_voice), 64'd0);
    load(44, 3);
    check("tp_load_b", 64'(bus.voice_load), 64'b0010);
    check("tp_last_b", 64'(bus.last_voice), 64'd1);
    load(47, 3);
    check("tp_load_c", 64'(bus.voice_load), 64'b0100);
    check("tp_last_c", 64'(bus.last_voice), 64'd2);
    check("tp_active3", 64'(bus.voice_active), 64'b0111);
    for (int k = 0; k < 3; k++) begin bus.beat = 1'b1; tick(); tick(); end
    check("tp_all_free", 64'(bus.voice_active), 64'd0);
    load(50, 3);
    check("tp_reuse_load", 64'(bus.voice_load), 64'b0001);
    check("tp_reuse_last", 64'(bus.last_voice), 64'd0);
    bus.play = 1'b0;
    for (int k = 0; k < 5; k++) begin bus.beat = 1'b1; tick(); end
    check("tp_frozen", 64'(bus.voice_active), 64'b0001);
    load(33, 0);
    check("tp_dur0_load", 64'(bus.voice_load), 64'd0);
    check("tp_dur0_drop", 64'(bus.note_dropped), 64'd0);
    bus.play = 1'b1;

    do_reset();
    load(1, 5); load(2, 2); load(3, 4); load(4, 2);
    load(9, 7);
`ifdef VOICE_STEAL_EN
    check("tp_full_load", 64'(bus.voice_load), 64'b0010);
    check("tp_full_drop", 64'(bus.note_dropped), 64'd0);
    check("tp_full_last", 64'(bus.last_voice), 64'd1);
`else
    check("tp_full_load", 64'(bus.voice_load), 64'd0);
    check("tp_full_drop", 64'(bus.note_dropped), 64'd1);
    check("tp_full_last", 64'(bus.last_voice), 64'd3);
`endif
    tick();
    check("tp_drop_clear", 64'(bus.note_dropped), 64'd0);

    do_reset();
    load(10, 60); load(11, 60);
    f_s[0] = 30000; f_s[1] = 10000; f_s[2] = 0; f_s[3] = 0;
    frame("mix_hi", 4, 1'b0);
    check("tp_sat_hi", 64'(nsr_val), 64'h7fff);
    f_s[0] = -30000; f_s[1] = -10000;
    frame("mix_lo", 4, 1'b0);
    check("tp_sat_lo", 64'(nsr_val), 64'h8000);

    do_reset();
    idle_latency("idle");

    load(12, 60);
    nsr_seen = 0;
    bus.voice_sample[SAMPLE_W-1:0] = 16'd1234;
    bus.generate_next_sample = 1'b1;
    tick(); tick(); tick();
    bus.generate_next_sample = 1'b1;
    tick(); tick(); tick();
    bus.voice_sample_ready = 4'b0001;
    tick();
    for (int k = 0; k < 6; k++) tick();
    check("gen_in_wait_pulses", 64'(nsr_seen), 64'd1);
    check("gen_in_wait_value", 64'(nsr_val), 64'd1234);

    nsr_seen = 0;
    bus.generate_next_sample = 1'b1;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_wait_vgen", 64'(bus.voice_generate), 64'd0);
    bus.voice_sample_ready = 4'b0001;
    tick();
    for (int k = 0; k < 5; k++) tick();
    check("rst_wait_pulses", 64'(nsr_seen), 64'd0);
    idle_latency("after_rst");

    do_reset();
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < 8; k++) begin
        rand_inputs();
        rst = ($urandom % 64) == 0;
        tick();
      end
      rst = 1'b0;
      bus.load_new_note = 1'b0;
      bus.beat = 1'b0;
      for (int i = 0; i < VOICES; i++) f_s[i] = int'($urandom_range(0, 65535)) - 32768;
      frame("rand_mix", int'($urandom_range(0, 3)), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
